// File: rtl/dsp_macc_pipe.sv
// dsp_macc_pipe: pipelined multiply-accumulate, p = [acc +] a*b + carryin, with valid tagging.
// Optional feature: define MACC_SAT_EN to clamp the accumulator to the P_WIDTH range and flag
// clamped beats on sat; left undefined the arithmetic wraps silently and sat is tied low.
module dsp_macc_pipe #(
  parameter int unsigned A_WIDTH     = 16,
  parameter int unsigned B_WIDTH     = 16,
  parameter int unsigned P_WIDTH     = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned SIGNED      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               carryin,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] p,
  output logic               sat
);

  // Stages ahead of the final accumulate register.
  localparam int unsigned NREG = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  logic signed [A_WIDTH:0]   a_x;
  logic signed [B_WIDTH:0]   b_x;
  logic signed [P_WIDTH-1:0] prod_c;

  // Operands extended by one bit so one signed multiplier serves both signedness modes.
  always_comb begin
    a_x = (SIGNED != 0) ? {a[A_WIDTH-1], a} : {1'b0, a};
    b_x = (SIGNED != 0) ? {b[B_WIDTH-1], b} : {1'b0, b};
    // P_WIDTH >= A_WIDTH+B_WIDTH, so the product is exact at this width.
    prod_c = P_WIDTH'(a_x) * P_WIDTH'(b_x);
  end

  logic               fin_vld;
  logic [P_WIDTH-1:0] fin_prod;
  logic               fin_cin;
  logic               fin_en;
  logic               fin_clr;

  if (PIPE_STAGES > 1) begin : g_pipe
    for (genvar g = 0; g < int'(NREG); g++) begin : g_stage
      logic               vld_d,  vld_q;
      logic [P_WIDTH-1:0] prod_d, prod_q;
      logic               cin_d,  cin_q;
      logic               en_d,   en_q;
      logic               clr_d,  clr_q;

      if (g == 0) begin : g_first
        // First stage captures the product and the controls that travel with it.
        always_comb begin
          vld_d  = in_valid;
          prod_d = prod_c;
          cin_d  = carryin;
          en_d   = acc_en;
          clr_d  = acc_clr;
        end
      end else begin : g_next
        // Later stages just shift the beat along.
        always_comb begin
          vld_d  = g_stage[g-1].vld_q;
          prod_d = g_stage[g-1].prod_q;
          cin_d  = g_stage[g-1].cin_q;
          en_d   = g_stage[g-1].en_q;
          clr_d  = g_stage[g-1].clr_q;
        end
      end

      // Stage register; reset flushes any beat in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q  <= 1'b0;
          prod_q <= '0;
          cin_q  <= 1'b0;
          en_q   <= 1'b0;
          clr_q  <= 1'b0;
        end else begin
          vld_q  <= vld_d;
          prod_q <= prod_d;
          cin_q  <= cin_d;
          en_q   <= en_d;
          clr_q  <= clr_d;
        end
      end
    end

    // Last pipeline stage feeds the accumulate stage.
    always_comb begin
      fin_vld  = g_stage[NREG-1].vld_q;
      fin_prod = g_stage[NREG-1].prod_q;
      fin_cin  = g_stage[NREG-1].cin_q;
      fin_en   = g_stage[NREG-1].en_q;
      fin_clr  = g_stage[NREG-1].clr_q;
    end
  end else begin : g_nopipe
    // Single stage: multiply and accumulate in the same cycle.
    always_comb begin
      fin_vld  = in_valid;
      fin_prod = prod_c;
      fin_cin  = carryin;
      fin_en   = acc_en;
      fin_clr  = acc_clr;
    end
  end

  logic               out_valid_d, out_valid_q;
  logic [P_WIDTH-1:0] acc_d, acc_q;
  logic [P_WIDTH-1:0] base_c;
  logic [P_WIDTH-1:0] res_c;

  // Clear takes priority; otherwise enable selects accumulate versus load.
  always_comb begin
    base_c = (fin_clr || !fin_en) ? '0 : acc_q;
  end

`ifdef MACC_SAT_EN
  localparam int unsigned SW = P_WIDTH + 2;
  localparam logic signed [SW-1:0] SMAX = SW'({1'b0, {(P_WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
  localparam logic signed [SW-1:0] UMAX = SW'({P_WIDTH{1'b1}});

  logic signed [SW-1:0] base_w;
  logic signed [SW-1:0] prod_w;
  logic signed [SW-1:0] sum_w;
  logic                 clamp_c;
  logic                 sat_d, sat_q;

  // Two guard bits make the true sum visible so it can be clamped to range.
  always_comb begin
    if (SIGNED != 0) begin
      base_w = SW'($signed(base_c));
      prod_w = SW'($signed(fin_prod));
    end else begin
      base_w = SW'(base_c);
      prod_w = SW'(fin_prod);
    end
    sum_w   = base_w + prod_w + SW'(fin_cin);
    res_c   = sum_w[P_WIDTH-1:0];
    clamp_c = 1'b0;
    if (SIGNED != 0) begin
      if (sum_w > SMAX) begin
        res_c   = SMAX[P_WIDTH-1:0];
        clamp_c = 1'b1;
      end else if (sum_w < SMIN) begin
        res_c   = SMIN[P_WIDTH-1:0];
        clamp_c = 1'b1;
      end
    end else if (sum_w > UMAX) begin
      res_c   = UMAX[P_WIDTH-1:0];
      clamp_c = 1'b1;
    end
  end

  // Saturation flag follows each beat and holds across bubbles.
  always_comb begin
    sat_d = sat_q;
    if (fin_vld) begin
      sat_d = clamp_c;
    end
  end

  // Saturation flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;
`else
  // Wrap-around sum modulo 2^P_WIDTH.
  always_comb begin
    res_c = base_c + fin_prod + P_WIDTH'(fin_cin);
  end

  assign sat = 1'b0;
`endif

  // Accumulator updates only on valid beats; bubbles hold it.
  always_comb begin
    out_valid_d = fin_vld;
    acc_d       = acc_q;
    if (fin_vld) begin
      acc_d = res_c;
    end
  end

  // Output stage register; p mirrors the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = acc_q;

endmodule

// File: tb/tb_dsp_macc_pipe.sv
// Bench for dsp_macc_pipe: four instances (signed PIPE 2/4/1, unsigned PIPE 1) share stimulus;
// a per-instance reference model fills a scoreboard that is drained as out_valid pulses arrive.
module tb_dsp_macc_pipe;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        carryin;
  logic        acc_en;
  logic        acc_clr;
  logic        ov [N];
  logic [31:0] pp [N];
  logic        sv [N];

  always #5 clk = ~clk;

  dsp_macc_pipe #(.PIPE_STAGES(2), .SIGNED(1)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .carryin(carryin),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[0]), .p(pp[0]), .sat(sv[0]));
  dsp_macc_pipe #(.PIPE_STAGES(4), .SIGNED(1)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .carryin(carryin),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[1]), .p(pp[1]), .sat(sv[1]));
  dsp_macc_pipe #(.PIPE_STAGES(1), .SIGNED(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .carryin(carryin),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[2]), .p(pp[2]), .sat(sv[2]));
  dsp_macc_pipe #(.PIPE_STAGES(1), .SIGNED(0)) u_u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .carryin(carryin),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov[3]), .p(pp[3]), .sat(sv[3]));

  typedef struct {
    int          inst;
    logic [31:0] p;
    logic        sat;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] acc_m  [N];
  logic [31:0] hold_p [N];
  logic        hold_s [N];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        rst_seen = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  function automatic int pipe_of(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit signed_of(input int i);
    return (i != 3);
  endfunction

  // Reference: exact 64-bit arithmetic, then clamp or wrap to 32 bits.
  function automatic void model(input logic [31:0] acc, input logic [15:0] ai, input logic [15:0] bi,
                                input logic ci, input logic en, input logic clr, input bit sgn,
                                output logic [31:0] res, output logic st);
    longint pa, pb, base, sum;
    if (sgn) begin
      pa = longint'($signed(ai));
      pb = longint'($signed(bi));
    end else begin
      pa = longint'(ai);
      pb = longint'(bi);
    end
    if (clr || !en) base = 0;
    else if (sgn)   base = longint'($signed(acc));
    else            base = longint'(acc);
    sum = base + pa * pb + longint'(ci);
    res = sum[31:0];
    st  = 1'b0;
`ifdef MACC_SAT_EN
    if (sgn) begin
      if (sum > 64'sd2147483647) begin
        res = 32'h7FFF_FFFF;
        st  = 1'b1;
      end else if (sum < -64'sd2147483648) begin
        res = 32'h8000_0000;
        st  = 1'b1;
      end
    end else if (sum > 64'sd4294967295) begin
      res = 32'hFFFF_FFFF;
      st  = 1'b1;
    end
`endif
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s inst%0d got %0h expected %0h", tag, i, got, exp);
    end
  endtask

  // Drive one cycle of inputs and push the model's expectation for each instance.
  task automatic step(input logic v, input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                      input logic en, input logic clr, input logic r);
    logic [31:0] res;
    logic        st;
    exp_t        keep [$];
    @(posedge clk);
    #1;
    rst = r; in_valid = v; a = ai; b = bi; carryin = ci; acc_en = en; acc_clr = clr;
    if (r) begin
      for (int i = 0; i < N; i++) acc_m[i] = '0;
      foreach (sb[k]) if (sb[k].due <= cyc) keep.push_back(sb[k]);
      sb = keep;
    end else if (v) begin
      for (int i = 0; i < N; i++) begin
        model(acc_m[i], ai, bi, ci, en, clr, signed_of(i), res, st);
        acc_m[i] = res;
        sb.push_back('{i, res, st, cyc + pipe_of(i)});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Output monitor: scoreboard pops on out_valid, hold checks on bubbles, reset checks.
  always @(negedge clk) begin
    if (rst_seen) begin
      for (int i = 0; i < N; i++) begin
        chk("rst_valid", i, 32'(ov[i]), 32'd0);
        chk("rst_p", i, pp[i], 32'd0);
        chk("rst_sat", i, 32'(sv[i]), 32'd0);
        hold_p[i] = '0;
        hold_s[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ov[i] === 1'b1) begin
          int idx;
          idx = -1;
          foreach (sb[k]) if (idx < 0 && sb[k].inst == i) idx = k;
          n_cmp++;
          assert (idx >= 0) else begin
            n_bad++;
            $error("FAIL unexpected_valid inst%0d got p=%0h expected no beat", i, pp[i]);
          end
          if (idx >= 0) begin
            chk("beat_p", i, pp[i], sb[idx].p);
            chk("beat_sat", i, 32'(sv[i]), 32'(sb[idx].sat));
            chk("latency", i, 32'(cyc), 32'(sb[idx].due));
            hold_p[i] = sb[idx].p;
            hold_s[i] = sb[idx].sat;
            sb.delete(idx);
          end
        end else begin
          chk("bubble_valid", i, 32'(ov[i]), 32'd0);
          chk("hold_p", i, pp[i], hold_p[i]);
          chk("hold_sat", i, 32'(sv[i]), 32'(hold_s[i]));
        end
      end
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      n_cmp++;
      assert (sb[k].due >= cyc) else begin
        n_bad++;
        $error("FAIL missing_beat inst%0d got none by cycle %0d expected at %0d", sb[k].inst, cyc, sb[k].due);
      end
      if (sb[k].due < cyc) sb.delete(k);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sat_hi, sat_lo, u_hi, u_lo;
    logic        sat_f;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carryin = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    for (int i = 0; i < N; i++) acc_m[i] = '0;
    repeat (3) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Steady load stream: 38*22+1 every beat.
    repeat (10) step(1'b1, 16'd38, 16'd22, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < N; i++) chk("load_837", i, pp[i], 32'd837);

    // Signedness: same bits, different interpretation.
    step(1'b1, 16'hFFFD, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < 3; i++) chk("signed_mul", i, pp[i], 32'hFFFF_FFEB);
    chk("unsigned_mul", 3, pp[3], 32'd458731);

    // Back-to-back accumulate chain; clear wins over enable on the first beat.
    step(1'b1, 16'd33, 16'd12, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 16'd33, 16'd12, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd33, 16'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < N; i++) chk("acc_reload", i, pp[i], 32'd396);

    // Bubble between beats; controls on the bubble must be ignored.
    step(1'b1, 16'd5, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd9, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd7, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < N; i++) chk("bubble_acc", i, pp[i], 32'd46);

    // Reset with beats in flight and a beat presented during reset.
    step(1'b1, 16'd9, 16'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'd4, 16'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'd2, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < N; i++) chk("post_rst", i, pp[i], 32'd6);

    // Positive overflow: build 0x7FFFFF00 then add 256.
    step(1'b1, 16'd32767, 16'd32767, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd32767, 16'd32767, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd2,     16'd32767, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd255,   16'd256,   1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd16,    16'd16,    1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
`ifdef MACC_SAT_EN
    sat_hi = 32'h7FFF_FFFF; sat_lo = 32'h8000_0000; sat_f = 1'b1;
`else
    sat_hi = 32'h8000_0000; sat_lo = 32'h4001_8000; sat_f = 1'b0;
`endif
    u_hi = 32'h8000_0000;
    u_lo = 32'hBFFE_8000;
    for (int i = 0; i < 3; i++) begin
      chk("ovf_pos_p", i, pp[i], sat_hi);
      chk("ovf_pos_sat", i, 32'(sv[i]), 32'(sat_f));
    end
    chk("ovf_pos_unsigned", 3, pp[3], u_hi);
    chk("ovf_pos_unsigned_sat", 3, 32'(sv[3]), 32'd0);

    // Negative overflow: three times -32768*32767.
    step(1'b1, 16'h8000, 16'd32767, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 16'h8000, 16'd32767, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_neg_p", i, pp[i], sat_lo);
      chk("ovf_neg_sat", i, 32'(sv[i]), 32'(sat_f));
    end
    chk("ovf_neg_unsigned", 3, pp[3], u_lo);

    // Randomised traffic, checked entirely through the scoreboard.
    for (int k = 0; k < 200; k++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 7) == 0), 1'b0);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
